// File: rtl/lifo_stack_ctl_if.sv
// Producer/consumer handshake bundle for the LIFO stack controller.
// The master side drives push/pop/data; the slave side (the stack) returns data and status.
interface lifo_stack_ctl_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, data_in, clr_err,
        input  data_out, valid_out, count, empty, full, almost_full, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in, clr_err,
        output data_out, valid_out, count, empty, full, almost_full, overflow, underflow
    );
endinterface

// File: rtl/lifo_stack_ctl.sv
// Parametrised LIFO with registered pop data, push+pop top replace, occupancy count,
// almost-full flag and sticky overflow/underflow errors.
module lifo_stack_ctl #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lifo_stack_ctl_if.slave       bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(AFULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             ovf_q;
    logic             udf_q;

    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_repl;
    logic             do_bypass;
    logic             ovf_set;
    logic             udf_set;

    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == DEPTH_C);
        wr_idx    = AW'(count_q);
        top_idx   = AW'(count_q - 1'b1);
        do_push   = bus.push & ~bus.pop & ~is_full;
        do_pop    = bus.pop & ~bus.push & ~is_empty;
        do_repl   = bus.push & bus.pop & ~is_empty;
        do_bypass = bus.push & bus.pop & is_empty;
        ovf_set   = bus.push & ~bus.pop & is_full;
        udf_set   = bus.pop & ~bus.push & is_empty;
    end

    // Storage is intentionally not reset; only count defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= bus.data_in;
        if (do_repl) mem[top_idx] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            valid_q <= do_pop | do_repl | do_bypass;
            if (do_pop || do_repl) dout_q <= mem[top_idx];
            else if (do_bypass)    dout_q <= bus.data_in;
            if (do_push)     count_q <= count_q + 1'b1;
            else if (do_pop) count_q <= count_q - 1'b1;
            // A new error in the same cycle as clr_err leaves the flag set.
            if (ovf_set)          ovf_q <= 1'b1;
            else if (bus.clr_err) ovf_q <= 1'b0;
            if (udf_set)          udf_q <= 1'b1;
            else if (bus.clr_err) udf_q <= 1'b0;
        end
    end

    assign bus.data_out    = dout_q;
    assign bus.valid_out   = valid_q;
    assign bus.count       = count_q;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (count_q >= THRESH_C);
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
endmodule

// File: tb/tb_lifo_stack_ctl.sv
// Directed-vector and reference-queue bench for lifo_stack_ctl (WIDTH=16, DEPTH=4, AFULL_THRESH=3).
module tb_lifo_stack_ctl;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned THRESH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lifo_stack_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lifo_stack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(THRESH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        p;
        logic        q;
        logic        c;
        logic [15:0] d;
        int          cnt;
        logic        v;
        logic [15:0] dout;
        logic        o;
        logic        u;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

    int          e_cnt;
    logic        e_valid;
    logic [15:0] e_dout;
    logic        e_ovf;
    logic        e_udf;
    logic [15:0] stk[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " count"}, 32'(bus.count), 32'(e_cnt));
        chk({tag, " valid_out"}, 32'(bus.valid_out), 32'(e_valid));
        chk({tag, " data_out"}, 32'(bus.data_out), 32'(e_dout));
        chk({tag, " empty"}, 32'(bus.empty), 32'(e_cnt == 0));
        chk({tag, " full"}, 32'(bus.full), 32'(e_cnt == DEPTH));
        chk({tag, " almost_full"}, 32'(bus.almost_full), 32'(e_cnt >= THRESH));
        chk({tag, " overflow"}, 32'(bus.overflow), 32'(e_ovf));
        chk({tag, " underflow"}, 32'(bus.underflow), 32'(e_udf));
    endtask

    task automatic step(input logic p, input logic q, input logic [15:0] d, input logic c);
        @(negedge clk);
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        bus.clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0; bus.clr_err = 1'b0;

        // push, pop, clr, din, count, valid, dout, ovf, udf
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'hA1, 1, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'hB2, 2, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'hC3, 3, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'hD4, 4, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'hEE, 4, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 3, 1'b1, 16'h00D4, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h00, 3, 1'b0, 16'h00D4, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 2, 1'b1, 16'h00C3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 1, 1'b1, 16'h00B2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 0, 1'b1, 16'h00A1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 0, 1'b0, 16'h00A1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h00, 0, 1'b0, 16'h00A1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h11, 1, 1'b0, 16'h00A1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h22, 2, 1'b0, 16'h00A1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 16'h33, 2, 1'b1, 16'h0022, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 1, 1'b1, 16'h0033, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 0, 1'b1, 16'h0011, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 16'h55, 0, 1'b1, 16'h0055, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h00, 0, 1'b0, 16'h0055, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h00, 0, 1'b0, 16'h0055, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h00, 0, 1'b0, 16'h0055, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h01, 1, 1'b0, 16'h0055, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h02, 2, 1'b0, 16'h0055, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h03, 3, 1'b0, 16'h0055, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h04, 4, 1'b0, 16'h0055, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 16'h99, 4, 1'b1, 16'h0004, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 3, 1'b1, 16'h0099, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h00, 2, 1'b1, 16'h0003, 1'b0, 1'b0});

        // Reset held while push/pop toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.push = i[0];
            bus.pop  = i[1];
            bus.data_in = 16'(i + 16'h40);
        end
        #1;
        e_cnt = 0; e_valid = 1'b0; e_dout = '0; e_ovf = 1'b0; e_udf = 1'b0;
        check_all("reset");
        @(negedge clk);
        bus.push = 1'b0; bus.pop = 1'b0;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].p, vecs[i].q, vecs[i].d, vecs[i].c);
            e_cnt = vecs[i].cnt; e_valid = vecs[i].v; e_dout = vecs[i].dout;
            e_ovf = vecs[i].o; e_udf = vecs[i].u;
            check_all($sformatf("vec%0d", i));
        end

        // Async reset between edges right after an accepted pop
        step(1'b0, 1'b1, 16'h0, 1'b0);
        chk("prepop valid_out", 32'(bus.valid_out), 32'd1);
        chk("prepop data_out", 32'(bus.data_out), 32'h0002);
        #2 rst_n = 1'b0;
        #1;
        e_cnt = 0; e_valid = 1'b0; e_dout = '0; e_ovf = 1'b0; e_udf = 1'b0;
        check_all("midreset");
        @(negedge clk);
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
        rst_n = 1'b1;
        stk.delete();

        for (int n = 0; n < 200; n++) begin
            logic p, q, c;
            logic [15:0] d;
            p = ($urandom_range(0, 9) < 5);
            q = ($urandom_range(0, 9) < 4);
            c = ($urandom_range(0, 9) == 0);
            d = 16'($urandom);
            if (c) begin e_ovf = 1'b0; e_udf = 1'b0; end
            if (p && q) begin
                if (stk.size() == 0) e_dout = d;
                else begin
                    e_dout = stk[stk.size() - 1];
                    stk[stk.size() - 1] = d;
                end
                e_valid = 1'b1;
            end else if (p) begin
                if (stk.size() == DEPTH) e_ovf = 1'b1;
                else stk.push_back(d);
                e_valid = 1'b0;
            end else if (q) begin
                if (stk.size() == 0) begin
                    e_udf = 1'b1;
                    e_valid = 1'b0;
                end else begin
                    e_dout = stk.pop_back();
                    e_valid = 1'b1;
                end
            end else begin
                e_valid = 1'b0;
            end
            e_cnt = stk.size();
            step(p, q, d, c);
            check_all($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
